// File: rtl/rename_alloc_stage.sv
// Decode-to-rename stage: allocates up to WIDTH physical registers per group from a
// circular free list, takes back retired registers, and rewinds on branch shootdown.
module rename_alloc_stage #(
  parameter int WIDTH             = 2,
  parameter int NUM_PREGS         = 64,
  parameter int NUM_AREGS         = 32,
  parameter int MAX_PREDICT_DEPTH = 4,
  localparam int D  = NUM_PREGS - NUM_AREGS,
  localparam int PB = $clog2(NUM_PREGS),
  localparam int TB = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1,
  localparam int DB = $clog2(D),
  localparam int PW = DB + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_need,
  input  logic                  in_ckpt,
  input  logic [TB-1:0]         in_ckpt_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*PB-1:0]   out_preg,
  output logic [WIDTH-1:0]      out_preg_valid,
  input  logic [WIDTH-1:0]      free_valid,
  input  logic [WIDTH*PB-1:0]   free_preg,
  input  logic                  shootdown,
  input  logic [TB-1:0]         shootdown_tag,
  output logic [PW-1:0]         num_free
);

  logic [PB-1:0]                fifo_q [D];
  logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]                num_free_q, num_free_d;
  logic [MAX_PREDICT_DEPTH-1:0] ckpt_valid_q;
  logic [PW-1:0]                ckpt_head_q [MAX_PREDICT_DEPTH];
  logic                         out_valid_q;
  logic [WIDTH*PB-1:0]          out_preg_q;
  logic [WIDTH-1:0]             out_pv_q;

  logic [PW-1:0]                n_alloc, n_free;
  logic [PW-1:0]                alloc_ptr [WIDTH];
  logic [PW-1:0]                free_ptr  [WIDTH];
  logic [WIDTH*PB-1:0]          alloc_preg;
  logic                         accept, sd_hit;

  // Number of set bits of v strictly below lane lim (lim = WIDTH gives the full count).
  function automatic logic [PW-1:0] popcnt_below(input logic [WIDTH-1:0] v, input int lim);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i < lim && v[i]) c = c + PW'(1);
    return c;
  endfunction

  always_comb begin
    n_alloc    = popcnt_below(in_need, WIDTH);
    n_free     = popcnt_below(free_valid, WIDTH);
    in_ready   = !shootdown && (!out_valid_q || out_ready) && (num_free_q >= n_alloc);
    accept     = in_valid && in_ready;
    sd_hit     = shootdown && ckpt_valid_q[shootdown_tag];
    alloc_preg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc_ptr[i] = head_q + popcnt_below(in_need, i);
      free_ptr[i]  = tail_q + popcnt_below(free_valid, i);
      if (in_need[i]) alloc_preg[i*PB +: PB] = fifo_q[alloc_ptr[i][DB-1:0]];
    end

    if (sd_hit)      head_d = ckpt_head_q[shootdown_tag];
    else if (accept) head_d = head_q + n_alloc;
    else             head_d = head_q;
    tail_d     = tail_q + n_free;
    num_free_d = tail_d - head_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < D; k++) fifo_q[k] <= PB'(NUM_AREGS + k);
      head_q       <= '0;
      tail_q       <= PW'(D);
      num_free_q   <= PW'(D);
      ckpt_valid_q <= '0;
      for (int t = 0; t < MAX_PREDICT_DEPTH; t++) ckpt_head_q[t] <= '0;
      out_valid_q  <= 1'b0;
      out_preg_q   <= '0;
      out_pv_q     <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (free_valid[i]) fifo_q[free_ptr[i][DB-1:0]] <= free_preg[i*PB +: PB];
      head_q     <= head_d;
      tail_q     <= tail_d;
      num_free_q <= num_free_d;

      // accept implies !shootdown, so checkpoint write and invalidate never collide
      if (accept && in_ckpt) begin
        ckpt_head_q[in_ckpt_tag]  <= head_q + n_alloc;
        ckpt_valid_q[in_ckpt_tag] <= 1'b1;
      end else if (sd_hit) begin
        ckpt_valid_q[shootdown_tag] <= 1'b0;
      end

      if (accept) begin
        out_valid_q <= 1'b1;
        out_preg_q  <= alloc_preg;
        out_pv_q    <= in_need;
      end else if (shootdown || out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (int'(num_free_q) + int'(n_free) - (accept ? int'(n_alloc) : 0) <= D)
        else $error("free list overflow: more registers returned than the list holds");
  end

  assign out_valid      = out_valid_q;
  assign out_preg       = out_preg_q;
  assign out_preg_valid = out_pv_q;
  assign num_free       = num_free_q;

endmodule

// File: tb/tb_rename_alloc_stage.sv
// Directed bench for rename_alloc_stage: a free-list model predicts each group,
// expected groups queue up at accept and are compared when they reach the output.
module tb_rename_alloc_stage;
  localparam int W  = 2;
  localparam int PB = 6;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, in_ckpt, out_valid, out_ready, shootdown;
  logic [W-1:0]  in_need, out_preg_valid, free_valid;
  logic [1:0]    in_ckpt_tag, shootdown_tag;
  logic [W*PB-1:0] out_preg, free_preg;
  logic [5:0]    num_free;

  always #5 clk = ~clk;

  rename_alloc_stage #(.WIDTH(2), .NUM_PREGS(64), .NUM_AREGS(32), .MAX_PREDICT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_need(in_need),
    .in_ckpt(in_ckpt), .in_ckpt_tag(in_ckpt_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_preg(out_preg), .out_preg_valid(out_preg_valid), .free_valid(free_valid),
    .free_preg(free_preg), .shootdown(shootdown), .shootdown_tag(shootdown_tag),
    .num_free(num_free)
  );

  typedef struct packed {
    logic [W*PB-1:0] preg;
    logic [W-1:0]    pv;
  } grp_t;

  grp_t sb[$];
  grp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   mfifo [32];
  int   mhead, mtail;
  bit   mov;
  int   mck_head [4];
  bit   mck_v [4];

  function automatic int mfree();
    return (mtail - mhead + 64) % 64;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mfifo[k] = 32 + k;
    mhead = 0;
    mtail = 32;
    mov   = 1'b0;
    for (int t = 0; t < 4; t++) begin mck_v[t] = 1'b0; mck_head[t] = 0; end
    sb.delete();
    cur = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_need = '0; in_ckpt = 1'b0; in_ckpt_tag = '0;
    free_valid = '0; free_preg = '0; shootdown = 1'b0; shootdown_tag = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_preg", out_preg, 0);
    chk("rst_out_pv", out_preg_valid, 0);
    chk("rst_num_free", num_free, 32);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock of stimulus starting at a negedge; returns at the following negedge.
  task automatic step(input bit v, input logic [1:0] need, input bit ck, input logic [1:0] ctag,
                      input logic [1:0] fv, input logic [11:0] fp, input bit sd,
                      input logic [1:0] stag, input bit ordy);
    int n, off;
    bit rdy, acc;
    grp_t g;
    in_valid = v; in_need = need; in_ckpt = ck; in_ckpt_tag = ctag;
    free_valid = fv; free_preg = fp; shootdown = sd; shootdown_tag = stag; out_ready = ordy;
    #1;
    n   = int'(need[0]) + int'(need[1]);
    rdy = !sd && (!mov || ordy) && (mfree() >= n);
    chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    if (acc) begin
      off = 0;
      g = '0;
      g.pv = need;
      for (int i = 0; i < W; i++)
        if (need[i]) begin
          g.preg[i*PB +: PB] = 6'(mfifo[(mhead + off) % 32]);
          off++;
        end
      sb.push_back(g);
      mhead = (mhead + n) % 64;
      if (ck) begin mck_head[ctag] = mhead; mck_v[ctag] = 1'b1; end
      mov = 1'b1;
    end else begin
      if (sd && mck_v[stag]) begin mhead = mck_head[stag]; mck_v[stag] = 1'b0; end
      if (sd || ordy) mov = 1'b0;
    end
    off = 0;
    for (int i = 0; i < W; i++)
      if (fv[i]) begin
        mfifo[(mtail + off) % 32] = int'(fp[i*PB +: PB]);
        off++;
      end
    mtail = (mtail + off) % 64;

    @(posedge clk); #1;
    if (acc) begin
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) cur = sb.pop_front();
    end
    chk("out_valid", out_valid, mov);
    if (mov) begin
      chk("out_preg", out_preg, cur.preg);
      chk("out_pv", out_preg_valid, cur.pv);
    end
    chk("num_free", num_free, mfree());
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // drain the whole list two at a time
    for (int k = 0; k < 16; k++) begin
      step(1, 2'b11, 0, 0, 0, 0, 0, 0, 1);
      if (k == 0) chk("first_grp", out_preg, {6'd33, 6'd32});
    end
    chk("drained", num_free, 0);
    step(1, 2'b11, 0, 0, 0, 0, 0, 0, 1);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);

    // free 40 while empty; allocatable only next cycle
    step(1, 2'b01, 0, 0, 2'b01, 12'd40, 0, 0, 1);
    step(1, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    chk("refill_40", out_preg[5:0], 40);

    for (int k = 0; k < 16; k++)
      step(0, 2'b00, 0, 0, 2'b11, {6'(33 + 2*k), 6'(32 + 2*k)}, 0, 0, 1);
    step(1, 2'b10, 0, 0, 0, 0, 0, 0, 1);
    chk("partial", out_preg, {6'd32, 6'd0});
    chk("partial_nf", num_free, 31);

    // checkpoint recovery
    do_reset();
    step(1, 2'b11, 0, 0, 0, 0, 0, 0, 1);
    step(1, 2'b11, 1, 2, 0, 0, 0, 0, 1);
    repeat (3) step(1, 2'b11, 0, 0, 0, 0, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0, 0, 1, 2, 1);
    chk("sd_nf", num_free, 28);
    chk("sd_ov", out_valid, 0);
    step(1, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    chk("post_sd", out_preg[5:0], 36);
    step(0, 2'b00, 0, 0, 0, 0, 1, 2, 1);
    chk("sd_stale_nf", num_free, 27);

    // shootdown and checkpoint on the same tag: no checkpoint is written
    step(1, 2'b11, 1, 3, 0, 0, 1, 3, 1);
    step(0, 2'b00, 0, 0, 0, 0, 1, 3, 1);
    chk("sd_same_tag_nf", num_free, 27);

    // backpressure
    step(1, 2'b11, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) step(1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_nf", num_free, 25);
    step(1, 2'b11, 0, 0, 0, 0, 0, 0, 1);
    chk("bp_release_nf", num_free, 23);

    // reset with a group in flight
    step(1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // wrap-around with one alloc and one free per cycle
    for (int k = 0; k < 40; k++) begin
      step(1, 2'b01, 0, 0, 2'b01, {6'd0, 6'((k*5 + 1) % 64)}, 0, 0, 1);
      chk("wrap_nf", num_free, 32);
      if (k == 32) chk("wrap_order", out_preg[5:0], 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rename_alloc_stage.md
# rename_alloc_stage

N-wide decode-to-rename pipeline stage with an integrated circular free list. Each cycle it accepts a group of up to WIDTH decoded micro-ops, allocates one physical register per lane that writes a destination, and registers the group towards rename. Up to WIDTH retired physical registers are returned per cycle. Per-branch checkpoints of the allocation pointer let a branch shootdown reclaim every register allocated after the mispredicted branch in a single cycle.

## Interface
- WIDTH, 2: lanes per group, 1..4
- NUM_PREGS, 64: physical registers
- NUM_AREGS, 32: architectural registers; pregs 0..NUM_AREGS-1 are mapped at reset and never sit in the list
- MAX_PREDICT_DEPTH, 4: checkpoint slots; a tag indexes a slot directly
- Derived values:
  - D = NUM_PREGS-NUM_AREGS; D must be a power of two.
  - PB = clog2(NUM_PREGS).
  - TB = clog2(MAX_PREDICT_DEPTH).
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input group valid
- in_ready  out  1  group accepted this cycle when in_valid && in_ready
- in_need  in  WIDTH  lane i needs a destination preg
- in_ckpt  in  1  group ends in a branch; checkpoint after this group's allocations
- in_ckpt_tag  in  TB  branch tag for the checkpoint
- out_valid  out  1  registered group valid
- out_ready  in  1  downstream accepts out group
- out_preg  out  WIDTH*PB  lane i preg at bits [i*PB +: PB]
- out_preg_valid  out  WIDTH  registered copy of in_need
- free_valid  in  WIDTH  lane i returns a preg
- free_preg  in  WIDTH*PB  returned pregs
- shootdown  in  1  branch mispredict flush
- shootdown_tag  in  TB  tag of the mispredicted branch
- num_free  out  clog2(D)+1  registered free count

## Operation
- Storage is a ring fifo[D] with head (allocate side) and tail (free side). Both pointers are clog2(D)+1 bits, with the MSB as a wrap bit.
- num_free = tail - head.
- Reset state:
  - fifo[k] = NUM_AREGS + k.
  - head = 0, tail = D, num_free = D.
  - All checkpoint valid bits = 0.
  - out_valid = 0, out_preg = 0, out_preg_valid = 0.
- Definitions:
  - n = popcount(in_need).
  - in_ready = !shootdown && (!out_valid || out_ready) && num_free >= n.
  - in_ready does not depend on in_valid.
- On accept:
  - Lane i receives fifo[head + popcount(in_need[i-1:0])]; lanes are compacted and lane 0 is the oldest.
  - head += n.
  - The output register loads the pregs and in_need, and out_valid = 1.
  - Lanes with need = 0 output preg 0.
- Checkpoint: on accept with in_ckpt=1, ckpt_head[tag] = head + n and ckpt_valid[tag] = 1. Rewriting a tag that is already valid overwrites it.
- Frees: valid lanes are written compacted at tail, in lane order, and tail += popcount(free_valid). Frees are accepted in every cycle, including shootdown cycles.
- Shootdown with ckpt_valid[tag]=1:
  - head = ckpt_head[tag].
  - ckpt_valid[tag] = 0.
  - out_valid = 0.
  - No group is accepted that cycle.
- Shootdown with an invalid tag: only out_valid is cleared and no input is accepted. Head is unchanged.
- Output hold: if out_valid && !out_ready and no accept occurs, the output register holds its value.
- If no accept occurs and out_ready=1, out_valid goes to 0.
- Free-count update: num_free_next = tail_next - head_next, which covers simultaneous alloc, free and shootdown.
- Overflow: a free that would make num_free > D is illegal. The simulation assertion fires and behaviour is undefined.

## Timing
- Allocation latency is 1 cycle: pregs appear on out_preg the cycle after accept.
- in_ready is combinational from shootdown, out_valid, out_ready, num_free and in_need.
- Freed pregs become allocatable the cycle after the free (registered count and tail).
- Back-to-back accepts sustain WIDTH allocations per cycle while num_free >= n.
- With reset asserted mid-operation, the next cycle shows the full reset state. In-flight outputs are dropped and all checkpoints are cleared.
- Shootdown and in_ckpt for the same tag in the same cycle: shootdown wins, and the checkpoint is not written because there is no accept.
- Wrap: pointer arithmetic is modulo 2D, and fifo is indexed with the low clog2(D) bits. No special case exists at the boundary.

## Test plan
- Reset, then WIDTH=2 groups with need=11 accepted every cycle with out_ready=1:
  - Expected outputs are 32/33, 34/35, … .
  - num_free decrements by 2 per cycle.
  - After 16 groups, num_free=0 and in_ready=0 for need!=00, while need=00 is still accepted.
- Empty list with simultaneous free of preg 40 and request need=01:
  - Same cycle: in_ready=0.
  - Next cycle: num_free=1, and the group is accepted with out_preg lane0 = 40.
- Partial lanes: need=10 outputs lane1 = next free preg with out_preg_valid=10 and lane0 preg 0; head advances by 1.
- Checkpoint recovery:
  - Accept need=11 with in_ckpt tag 2 after 2 allocations (head=4).
  - Allocate 3 more groups, then assert shootdown tag 2.
  - Required: num_free=28, out_valid=0, and the next allocation returns preg 36.
- Backpressure: hold out_ready=0 with out_valid=1. Required: outputs are stable, in_ready=0, and head is unchanged. Releasing out_ready allows an accept in the same cycle.
- Wrap-around: after 40 alloc/free pairs of one preg each (pointers wrapped), pregs come out in the same order they were freed, and num_free stays at 32.
